// File: rtl/renderer_linha_if.sv
// Map-memory request/acknowledge bus between the tile renderer (master) and
// the map memory (slave). Coordinates are tile indices, data is one tile colour.
interface renderer_linha_if #(
    parameter int COLOR_BITS = 6
);
    logic [9:0]            mapa_x;
    logic [9:0]            mapa_y;
    logic                  mapa_read;
    logic                  mapa_valid;
    logic [COLOR_BITS-1:0] mapa_cor;

    modport master (
        output mapa_x, mapa_y, mapa_read,
        input  mapa_valid, mapa_cor
    );

    modport slave (
        input  mapa_x, mapa_y, mapa_read,
        output mapa_valid, mapa_cor
    );
endinterface

// File: rtl/renderer_linha.sv
// Tile renderer: prefetches tile rows into a ping-pong line buffer and serves pixels from it.
// Optional grid overlay enabled by defining RENDERER_GRID_EN.
module renderer_linha #(
    parameter int                     SCREEN_WIDTH  = 640,
    parameter int                     SCREEN_HEIGHT = 480,
    parameter int                     BLOCK_BITS    = 4,
    parameter int                     COLOR_BITS    = 6,
    parameter logic [COLOR_BITS-1:0]  GRID_COR      = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pixel_read,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    output logic [COLOR_BITS-1:0] cor,
    output logic                  cor_valid,
    output logic                  underflow,
    renderer_linha_if.master      mapa
);
    localparam int TILES_X = SCREEN_WIDTH >> BLOCK_BITS;
    localparam int TILES_Y = SCREEN_HEIGHT >> BLOCK_BITS;
    localparam int TXW     = (TILES_X > 1) ? $clog2(TILES_X) : 1;

    localparam logic [9:0] SW10    = 10'(SCREEN_WIDTH);
    localparam logic [9:0] SH10    = 10'(SCREEN_HEIGHT);
    localparam logic [9:0] FX_LAST = 10'(TILES_X - 1);
    localparam logic [9:0] TY_LAST = 10'(TILES_Y - 1);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t          r_state;
    logic [9:0]      r_fx;
    logic [9:0]      r_row;
    logic            r_pend_valid;
    logic [9:0]      r_pend_row;
    logic [9:0]      r_tag [2];
    logic [1:0]      r_tag_valid;
    logic [9:0]      r_last_ty;
    logic [COLOR_BITS-1:0] r_cor;
    logic            r_cor_valid;
    logic            r_underflow;

    logic [9:0]      w_ty;
    logic [TXW-1:0]  w_tx_idx;
    logic            w_in_range;
    logic            w_hit;
    logic            w_done;
    logic            w_wr_en;
    logic            w_start;
    logic            w_busy;
    logic [9:0]      w_row;
    logic            w_pend_v;
    logic [9:0]      w_pend_row;
    logic [2:0]      w_trig_en;
    logic [9:0]      w_trig_row [3];
    logic [COLOR_BITS-1:0] w_rd [2];
    logic [COLOR_BITS-1:0] w_pix_cor;

    assign w_ty       = pixel_y >> BLOCK_BITS;
    assign w_tx_idx   = TXW'(pixel_x >> BLOCK_BITS);
    assign w_in_range = (pixel_x < SW10) && (pixel_y < SH10);
    assign w_hit      = r_tag_valid[w_ty[0]] && (r_tag[w_ty[0]] == w_ty);

    assign w_wr_en = (r_state == S_FETCH) && mapa.mapa_valid;
    assign w_done  = w_wr_en && (r_fx == FX_LAST);

    // Triggers in age order: frame_start brings rows 0 then 1, the beam trigger is newest.
    assign w_trig_en[0]  = frame_start;
    assign w_trig_en[1]  = frame_start && (TILES_Y > 1);
    assign w_trig_en[2]  = pixel_read && (w_ty != r_last_ty) && (w_ty < TY_LAST);
    assign w_trig_row[0] = 10'd0;
    assign w_trig_row[1] = 10'd1;
    assign w_trig_row[2] = w_ty + 10'd1;

    // Resolve what the fetch slot and the pending slot hold after this cycle.
    always_comb begin
        w_busy     = 1'b0;
        w_row      = r_row;
        w_pend_v   = r_pend_valid;
        w_pend_row = r_pend_row;
        if (r_state == S_FETCH && !w_done) begin
            w_busy = 1'b1;
        end else if (r_pend_valid) begin
            w_busy   = 1'b1;
            w_row    = r_pend_row;
            w_pend_v = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            if (w_trig_en[k]) begin
                if (!w_busy) begin
                    w_busy = 1'b1;
                    w_row  = w_trig_row[k];
                end else if (w_trig_row[k] != w_row) begin
                    w_pend_v   = 1'b1;
                    w_pend_row = w_trig_row[k];
                end
            end
        end
    end

    assign w_start = w_busy && !(r_state == S_FETCH && !w_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fx         <= '0;
            r_row        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_row   <= '0;
            r_tag_valid  <= '0;
            r_tag[0]     <= '0;
            r_tag[1]     <= '0;
        end else begin
            r_pend_valid <= w_pend_v;
            r_pend_row   <= w_pend_row;
            if (w_done) begin
                r_tag[r_row[0]]       <= r_row;
                r_tag_valid[r_row[0]] <= 1'b1;
            end
            // A new fetch invalidates its bank after any completion above, so row r+2 wins.
            if (w_start) begin
                r_state                <= S_FETCH;
                r_fx                   <= '0;
                r_row                  <= w_row;
                r_tag_valid[w_row[0]]  <= 1'b0;
            end else if (w_busy) begin
                if (w_wr_en)
                    r_fx <= r_fx + 10'd1;
            end else begin
                r_state <= S_IDLE;
                r_fx    <= '0;
            end
        end
    end

    assign mapa.mapa_read = (r_state == S_FETCH);
    assign mapa.mapa_x    = r_fx;
    assign mapa.mapa_y    = r_row;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [COLOR_BITS-1:0] r_mem [TILES_X];
            always_ff @(posedge clk) begin
                if (!reset && w_wr_en && (r_row[0] == 1'(gi)))
                    r_mem[r_fx[TXW-1:0]] <= mapa.mapa_cor;
            end
            assign w_rd[gi] = r_mem[w_tx_idx];
        end
    endgenerate

    always_comb begin
        w_pix_cor = w_hit ? w_rd[w_ty[0]] : '0;
`ifdef RENDERER_GRID_EN
        if (pixel_x[BLOCK_BITS-1:0] == '0 || pixel_y[BLOCK_BITS-1:0] == '0)
            w_pix_cor = GRID_COR;
`endif
        if (!w_in_range)
            w_pix_cor = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cor       <= '0;
            r_cor_valid <= 1'b0;
            r_underflow <= 1'b0;
            r_last_ty   <= '1;
        end else begin
            r_cor_valid <= pixel_read;
            if (pixel_read) begin
                r_last_ty <= w_ty;
                r_cor     <= w_pix_cor;
                if (w_in_range && !w_hit)
                    r_underflow <= 1'b1;
            end
        end
    end

    assign cor       = r_cor;
    assign cor_valid = r_cor_valid;
    assign underflow = r_underflow;
endmodule

// File: tb/tb_renderer_linha.sv
// Scoreboard bench for renderer_linha: 64x32 screen, 16-pixel tiles, map returns y*8+x.
module tb_renderer_linha;
    localparam int CB = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          pixel_read = 1'b0;
    logic [9:0]    pixel_x = '0;
    logic [9:0]    pixel_y = '0;
    logic [CB-1:0] cor;
    logic          cor_valid;
    logic          underflow;

    renderer_linha_if #(.COLOR_BITS(CB)) bus();

    renderer_linha #(
        .SCREEN_WIDTH(64), .SCREEN_HEIGHT(32), .BLOCK_BITS(4),
        .COLOR_BITS(CB), .GRID_COR(6'h3F)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .pixel_read(pixel_read), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .cor(cor), .cor_valid(cor_valid), .underflow(underflow),
        .mapa(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 0;
    int wait_cnt = 0;
    int ack_cnt = 0;
    int ack_first = -1;
    int ack_last = -1;
    logic          hold_pend = 1'b0;
    logic [19:0]   hold_xy = '0;
    logic [19:0]   exp_map [$];
    logic [CB-1:0] exp_cor [$];

    // Map memory model: acknowledges after lat waiting cycles (0 = same cycle).
    assign bus.mapa_valid = bus.mapa_read && (wait_cnt >= lat);
    assign bus.mapa_cor   = CB'(bus.mapa_y * 8 + bus.mapa_x);

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset || !bus.mapa_read || bus.mapa_valid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Map monitor: request order and request stability while waiting for acknowledge.
    initial forever begin
        @(negedge clk);
        if (!reset && bus.mapa_read) begin
            if (hold_pend) chk("map_hold", {bus.mapa_x, bus.mapa_y}, hold_xy);
            if (bus.mapa_valid) begin
                ack_cnt++;
                if (ack_first < 0) ack_first = cyc;
                ack_last = cyc;
                hold_pend = 1'b0;
                if (exp_map.size() == 0) chk("map_extra", {bus.mapa_x, bus.mapa_y}, 32'hFFFFF);
                else chk("map_req", {bus.mapa_x, bus.mapa_y}, exp_map.pop_front());
            end else begin
                hold_pend = 1'b1;
                hold_xy   = {bus.mapa_x, bus.mapa_y};
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    // Pixel monitor.
    initial forever begin
        @(negedge clk);
        if (cor_valid) begin
            if (exp_cor.size() == 0) chk("cor_extra", 32'(cor), 32'hFFFF);
            else chk("cor", 32'(cor), 32'(exp_cor.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input int r);
        for (int x = 0; x < 4; x++) exp_map.push_back({10'(x), 10'(r)});
    endtask

    task automatic wait_map(input string nm, input int budget);
        int n = 0;
        while (exp_map.size() != 0 && n < budget) begin tick(); n++; end
        chk(nm, exp_map.size(), 0);
        exp_map.delete();
    endtask

    task automatic wait_cor(input string nm);
        int n = 0;
        while (exp_cor.size() != 0 && n < 10) begin tick(); n++; end
        chk(nm, exp_cor.size(), 0);
        exp_cor.delete();
    endtask

    task automatic pix(input int x, input int y, input logic [CB-1:0] e);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        pixel_read = 1'b1;
        exp_cor.push_back(e);
        tick();
        pixel_read = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_map.delete();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        tick(); tick();
        chk("rst_cor", 32'(cor), 0);
        chk("rst_cor_valid", 32'(cor_valid), 0);
        chk("rst_mapa_read", 32'(bus.mapa_read), 0);
        chk("rst_mapa_x", 32'(bus.mapa_x), 0);
        chk("rst_mapa_y", 32'(bus.mapa_y), 0);
        chk("rst_underflow", 32'(underflow), 0);
        reset = 1'b0;

        // 1: zero-latency map, 8 back-to-back reads
        lat = 0; ack_cnt = 0; ack_first = -1;
        push_row(0); push_row(1);
        frame();
        wait_map("t1_map_drain", 60);
        chk("t1_acks", ack_cnt, 8);
        chk("t1_span", ack_last - ack_first, 7);
        tick(); tick();
        chk("t1_read_idle", 32'(bus.mapa_read), 0);
        push_row(1);
        pix(20, 5, 6'd1);
        wait_map("t1_refetch", 60);
        wait_cor("t1_cor_drain");
        chk("t1_underflow", 32'(underflow), 0);

        // 2: 3-cycle map latency, then stream lines 16..31
        lat = 3;
        push_row(0); push_row(1);
        frame();
        wait_map("t2_map_drain", 200);
        for (int y = 16; y < 32; y++) begin
            for (int x = 0; x < 64; x++) begin
                pixel_x = 10'(x);
                pixel_y = 10'(y);
                pixel_read = 1'b1;
                exp_cor.push_back(CB'(8 + (x >> 4)));
                tick();
            end
        end
        pixel_read = 1'b0;
        tick();
        wait_cor("t2_cor_drain");
        chk("t2_underflow", 32'(underflow), 0);

        // 3: no frame_start -> underflow, sticky until reset
        do_reset();
        lat = 3;
        push_row(1);
        pix(0, 0, 6'd0);
        chk("t3_underflow_set", 32'(underflow), 1);
        wait_map("t3_map_drain", 100);
        pix(5, 16, 6'd8);
        wait_cor("t3_cor_drain");
        chk("t3_underflow_sticky", 32'(underflow), 1);
        do_reset();
        chk("t3_underflow_clear", 32'(underflow), 0);

        // 4: reset during the second read of a fetch
        lat = 0;
        push_row(0); push_row(1);
        frame();
        wait_map("t4_fill", 60);
        lat = 3; ack_cnt = 0;
        push_row(0); push_row(1);
        frame();
        n = 0;
        while (ack_cnt < 1 && n < 50) begin tick(); n++; end
        chk("t4_first_ack", ack_cnt, 1);
        chk("t4_second_req", {bus.mapa_read, bus.mapa_x}, {1'b1, 10'd1});
        reset = 1'b1;
        tick();
        chk("t4_read_drop", 32'(bus.mapa_read), 0);
        reset = 1'b0;
        exp_map.delete();
        pix(0, 16, 6'd0);
        wait_cor("t4_cor_inval");
        chk("t4_tag_invalid", 32'(underflow), 1);
        do_reset();
        lat = 0;
        push_row(0); push_row(1);
        frame();
        wait_map("t4_refill", 60);
        push_row(1);
        pix(20, 5, 6'd1);
        wait_map("t4_refetch", 60);
        pix(33, 20, 6'd10);
        wait_cor("t4_cor_drain");

        // 5: triggers while fetching; out-of-range pixel
        do_reset();
        lat = 3; ack_cnt = 0;
        push_row(0); push_row(1);
        frame();
        tick();
        pix(70, 5, 6'd0);
        chk("t5_oor_no_underflow", 32'(underflow), 0);
        frame();
        wait_map("t5_map_drain", 200);
        repeat (20) tick();
        chk("t5_acks", ack_cnt, 8);
        pix(20, 5, 6'd1);
        pix(33, 20, 6'd10);
        wait_cor("t5_cor_drain");
        chk("t5_underflow", 32'(underflow), 0);

        // 6: grid overlay
        lat = 0;
        push_row(1);
`ifdef RENDERER_GRID_EN
        pix(16, 3, 6'h3F);
`else
        pix(16, 3, 6'd1);
`endif
        pix(17, 3, 6'd1);
        wait_map("t6_map_drain", 60);
        wait_cor("t6_cor_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/renderer_linha.md
Name: renderer_linha

Overview:
- Next-generation tile renderer for the VGA path.
- Prefetches each row of map tiles into a ping-pong line buffer ahead of the beam, then serves pixel colours from that buffer, so the map memory is read once per tile, not once per pixel.
- Sits between the VGA sync generator (pixel_read/pixel_x/pixel_y) and the map memory (mapa_* request/acknowledge).
- Decouples map latency from pixel timing and flags any buffer underrun.

Parameters:
- SCREEN_WIDTH, 640, visible pixels per line; must be a multiple of 2**BLOCK_BITS.
- SCREEN_HEIGHT, 480, visible lines; must be a multiple of 2**BLOCK_BITS.
- BLOCK_BITS, 4, log2 of tile edge in pixels; tile edge BLOCK_SIZE = 2**BLOCK_BITS.
- COLOR_BITS, 6, colour word width.
- GRID_COR, 0, grid colour; used only with RENDERER_GRID_EN.

Derived values:
- TILES_X = SCREEN_WIDTH>>BLOCK_BITS.
- TILES_Y = SCREEN_HEIGHT>>BLOCK_BITS.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse during vblank before line 0
- pixel_read  in  1  beam is in the visible area this cycle
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel line
- cor  out  COLOR_BITS  pixel colour, registered
- cor_valid  out  1  cor corresponds to the pixel_read of the previous cycle
- mapa_x  out  10  tile column requested
- mapa_y  out  10  tile row requested
- mapa_read  out  1  map read request
- mapa_valid  in  1  map acknowledge; mapa_cor is valid this cycle
- mapa_cor  in  COLOR_BITS  tile colour
- underflow  out  1  sticky: a pixel hit a bank not holding its row

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: cor=0, cor_valid=0, mapa_read=0, mapa_x=0, mapa_y=0, underflow=0. FSM goes to IDLE, both bank tags are invalidated and the pending trigger is cleared.
- Reset mid-fetch drops the fetch. No write to the buffer occurs in the reset cycle.
- Storage: two banks of TILES_X x COLOR_BITS.
  - Each bank has a tag (row index) and a valid bit.
  - Row r always lives in bank r[0].
- Triggers:
  - frame_start queues rows 0 and 1. frame_start does not invalidate tags.
  - When pixel_read=1 and tile row ty=pixel_y>>BLOCK_BITS differs from the last displayed row, queue row ty+1 if ty+1<TILES_Y.
  - The "last displayed row" register is reset to all-ones, so row 0 counts as a change.
- Queue: the current fetch plus one pending slot.
  - A trigger arriving while the slot is full overwrites it; the newest row wins.
  - A trigger for the row already being fetched is ignored.
  - Triggers arriving in the same cycle as fetch completion are honoured.
- FSM, IDLE:
  - Pending present → FETCH with fx=0. The target bank's valid bit is cleared on entry.
- FSM, FETCH:
  - mapa_read=1, mapa_x=fx, mapa_y=row.
  - mapa_x, mapa_y and mapa_read are held stable until mapa_valid. One outstanding request at a time.
  - mapa_valid may be asserted in the same cycle as mapa_read (zero-latency memory) or any number of cycles later.
  - On mapa_valid: write bank[row[0]][fx] ← mapa_cor, then fx++.
  - If fx==TILES_X-1: set tag=row and valid=1, then go to IDLE, or straight to FETCH of the pending row with no idle cycle.
  - mapa_read drops in the cycle after the final acknowledge unless the next fetch starts.
- Pixel path, 1-cycle latency: when pixel_read=1, the next cycle gives cor=bank[ty[0]][pixel_x>>BLOCK_BITS] and cor_valid=1.
- Underflow: if the bank is invalid or its tag≠ty, then cor=0 and underflow is set. underflow stays set until reset.
- When pixel_read=0, in the next cycle cor holds its value and cor_valid=0.
- Width rules: tile indices are truncated shifts of the 10-bit coordinates. Pixels with pixel_x≥SCREEN_WIDTH or pixel_y≥SCREEN_HEIGHT output 0 and do not set underflow.

Optional Feature:
- Macro: RENDERER_GRID_EN.
- Defined: any pixel with pixel_x[BLOCK_BITS-1:0]==0 or pixel_y[BLOCK_BITS-1:0]==0 outputs GRID_COR instead of the buffer colour, with the same 1-cycle latency. Underflow checking is unchanged.
- Not defined: no grid logic is present and GRID_COR is unused.

Test Plan:
- Common bench setup: SCREEN_WIDTH=64, SCREEN_HEIGHT=32, BLOCK_BITS=4, so TILES_X=4 and TILES_Y=2. Map model returns cor = mapa_y*8 + mapa_x.
1. Zero-latency map: frame_start → exactly 8 acknowledged reads, order (0,0)..(3,0),(0,1)..(3,1), with no gap between rows. Then scan pixel (20,5) → cor=1 one cycle later, cor_valid=1.
2. Map latency 3 cycles: mapa_x/mapa_y stay stable for 3 cycles per request. Full scan of lines 16..31 gives cor=8+tile_x, e.g. pixel (63,31) → 11, underflow=0.
3. No frame_start, scan pixel (0,0) → cor=0 and underflow=1. underflow stays 1 through the rest of the frame and clears only on reset.
4. Assert reset during the 2nd fetch read → mapa_read=0 next cycle, tags invalid. A new frame_start refetches both rows correctly.
5. Trigger while fetching plus second trigger → only the newest pending row is fetched. Pixel (70,5) (out of range) → cor=0, underflow unchanged.
6. With RENDERER_GRID_EN and GRID_COR=6'h3F: pixel (16,3) → 0x3F, pixel (17,3) → 1. Without the macro, pixel (16,3) → 1.
